// File: rtl/stream_mux_n_pkg.sv
// Shared definitions for the stream mux family: FSM encodings, parameter bounds, index helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package stream_mux_n_pkg;

  // FSM encodings, kept as plain vectors so older mux blocks can reuse them unchanged.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Legal parameter ranges for the mux family.
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;
  localparam int W_MIN = 1;
  localparam int W_MAX = 32;

  // Channel index increment with wrap from n-1 back to 0.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_arb.sv
// Combinational arbiter: picks one requesting channel, round-robin from a start index or fixed priority.
// Latency: 0 cycles (pure combinational winner/found).
// Backpressure: none; the caller decides when to sample the result.
module rr_arbiter_n
  import stream_mux_n_pkg::*;
#(
  parameter int N  = 4,
  parameter int RR = 1
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [$clog2(N)-1:0] winner_o,
  output logic                 found_o
);

  localparam int GW = $clog2(N);

  // Walk all channels once starting at start_i (or 0 for fixed priority); first requester wins.
  always_comb begin
    int idx;
    winner_o = '0;
    found_o  = 1'b0;
    idx      = (RR != 0) ? int'(start_i) : 0;
    for (int k = 0; k < N; k++) begin
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = GW'(idx);
      end
      idx = wrap_inc(idx, N);
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// Packet-atomic N:1 stream mux: arbitrates in IDLE, then locks one channel until its last beat.
// Latency: 1 cycle input-to-output through a single output register; 1 beat/cycle while locked.
// Backpressure: locked channel's in_ready = (!out_valid || out_ready); output holds while stalled.
module stream_mux_n
  import stream_mux_n_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RR = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] grant,
  output logic                 busy
);

  localparam int GW = $clog2(N);

  if (N < N_MIN || N > N_MAX || W < W_MIN || W > W_MAX) begin : g_bad_params
    $error("stream_mux_n: N or W outside supported range");
  end

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;        // next round-robin search start
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic [W-1:0]  ch_data [N];
  logic [GW-1:0] arb_winner;
  logic          arb_found;
  logic          lock;
  logic          out_free;
  logic          accept;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign ch_data[i] = in_data[i*W +: W];
  end

  rr_arbiter_n #(
    .N  (N),
    .RR (RR)
  ) u_arb (
    .req_i    (in_valid),
    .start_i  (ptr_q),
    .winner_o (arb_winner),
    .found_o  (arb_found)
  );

  assign lock     = (state_q == ST_LOCK);
  assign out_free = !out_valid_q || out_ready;
  assign accept   = lock && in_valid[grant_q] && out_free;

  // Only the locked channel may see ready, and only when the output register can take a beat.
  always_comb begin
    in_ready = '0;
    if (lock) in_ready[grant_q] = out_free;
  end

  // Arbitrate in IDLE; stay locked through gaps in valid until the last beat is accepted.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (state_q == ST_IDLE) begin
      if (arb_found) begin
        state_d = ST_LOCK;
        grant_d = arb_winner;
        ptr_d   = GW'(wrap_inc(int'(arb_winner), N));
      end
    end else if (accept && in_last[grant_q]) begin
      state_d = ST_IDLE;
    end
  end

  // Output register loads on accept, drains on out_ready, otherwise holds.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_q];
      out_last_d  = in_last[grant_q];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any held beat and lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant     = grant_q;
  assign busy      = lock;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench: round-robin instance (a_*) and fixed-priority instance (b_*).
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: exercised on the round-robin instance via a_ordy.
module tb_stream_mux_n;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]   a_vld, a_lst, a_rdy;
  logic [N*W-1:0] a_dat;
  logic           a_ovld, a_olst, a_ordy, a_busy;
  logic [W-1:0]   a_odat;
  logic [1:0]     a_gnt;

  logic [N-1:0]   b_vld, b_lst, b_rdy;
  logic [N*W-1:0] b_dat;
  logic           b_ovld, b_olst, b_ordy, b_busy;
  logic [W-1:0]   b_odat;
  logic [1:0]     b_gnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stream_mux_n #(.N(N), .W(W), .RR(1)) u_rr (
    .clk(clk), .rst(rst),
    .in_valid(a_vld), .in_data(a_dat), .in_last(a_lst), .in_ready(a_rdy),
    .out_valid(a_ovld), .out_data(a_odat), .out_last(a_olst), .out_ready(a_ordy),
    .grant(a_gnt), .busy(a_busy)
  );

  stream_mux_n #(.N(N), .W(W), .RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .in_valid(b_vld), .in_data(b_dat), .in_last(b_lst), .in_ready(b_rdy),
    .out_valid(b_ovld), .out_data(b_odat), .out_last(b_olst), .out_ready(b_ordy),
    .grant(b_gnt), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input int ch, input logic v, input logic [7:0] d, input logic l);
    a_vld[ch]        = v;
    a_dat[ch*W +: W] = d;
    a_lst[ch]        = l;
  endtask

  task automatic b_set(input int ch, input logic v, input logic [7:0] d, input logic l);
    b_vld[ch]        = v;
    b_dat[ch*W +: W] = d;
    b_lst[ch]        = l;
  endtask

  int exp_g [5] = '{0, 1, 2, 3, 0};

  initial begin
    a_vld = '0; a_dat = '0; a_lst = '0; a_ordy = 1'b1;
    b_vld = '0; b_dat = '0; b_lst = '0; b_ordy = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ovld",  a_ovld, 0);
    check("rst_odat",  a_odat, 0);
    check("rst_olast", a_olst, 0);
    check("rst_grant", a_gnt,  0);
    check("rst_busy",  a_busy, 0);
    check("rst_rdy",   a_rdy,  0);
    rst = 1'b0;

    // single channel: ch2 sends 11, 22, 33(last)
    a_set(2, 1, 8'h11, 0);
    step();
    check("sc_busy",  a_busy, 1);
    check("sc_grant", a_gnt,  2);
    check("sc_rdy",   a_rdy,  4'b0100);
    check("sc_ovld0", a_ovld, 0);
    step();
    check("sc_d11",   a_odat, 8'h11);
    check("sc_v11",   a_ovld, 1);
    check("sc_l11",   a_olst, 0);
    a_set(2, 1, 8'h22, 0);
    step();
    check("sc_d22",   a_odat, 8'h22);
    a_set(2, 1, 8'h33, 1);
    step();
    check("sc_d33",   a_odat, 8'h33);
    check("sc_l33",   a_olst, 1);
    check("sc_idle",  a_busy, 0);
    a_set(2, 0, 8'h00, 0);
    step();
    check("sc_drain", a_ovld, 0);

    // round-robin fairness from a fresh pointer
    rst = 1'b1; #1; rst = 1'b0;
    for (int c = 0; c < N; c++) a_set(c, 1, 8'hA0 + 8'(c), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_grant", a_gnt, exp_g[i]);
      step();
      check("rr_data", a_odat, 32'hA0 + exp_g[i]);
      check("rr_last", a_olst, 1);
    end
    a_vld = '0;
    step();

    // backpressure mid-packet on ch1: 41, 42, stall, 43, 44(last)
    a_set(1, 1, 8'h41, 0);
    step();
    check("bp_grant", a_gnt, 1);
    step();
    check("bp_d41", a_odat, 8'h41);
    a_set(1, 1, 8'h42, 0);
    step();
    check("bp_d42", a_odat, 8'h42);
    a_ordy = 1'b0;
    a_set(1, 1, 8'h43, 0);
    #1;
    check("bp_rdy_low", a_rdy, 0);
    repeat (5) begin
      step();
      check("bp_hold_d", a_odat, 8'h42);
      check("bp_hold_v", a_ovld, 1);
      check("bp_hold_r", a_rdy,  0);
    end
    a_ordy = 1'b1;
    #1;
    check("bp_rdy_back", a_rdy, 4'b0010);
    step();
    check("bp_d43", a_odat, 8'h43);
    a_set(1, 1, 8'h44, 1);
    step();
    check("bp_d44", a_odat, 8'h44);
    check("bp_l44", a_olst, 1);
    check("bp_idle", a_busy, 0);
    a_set(1, 0, 8'h00, 0);
    step();
    check("bp_drain", a_ovld, 0);

    // lock hold: ch1 stalls mid-packet while ch0 waits
    a_set(1, 1, 8'h51, 0);
    step();
    check("lh_grant", a_gnt, 1);
    a_set(0, 1, 8'h61, 1);
    step();
    check("lh_d51", a_odat, 8'h51);
    a_set(1, 0, 8'h00, 0);
    repeat (3) begin
      step();
      check("lh_grant_hold", a_gnt,  1);
      check("lh_busy_hold",  a_busy, 1);
      check("lh_rdy_hold",   a_rdy,  4'b0010);
    end
    check("lh_ovld_gap", a_ovld, 0);
    a_set(1, 1, 8'h52, 1);
    step();
    check("lh_d52", a_odat, 8'h52);
    check("lh_l52", a_olst, 1);
    check("lh_idle", a_busy, 0);
    a_set(1, 0, 8'h00, 0);
    step();
    check("lh_ch0_grant", a_gnt, 0);
    step();
    check("lh_d61", a_odat, 8'h61);
    a_set(0, 0, 8'h00, 0);
    step();

    // reset asserted mid-packet on ch3
    a_set(3, 1, 8'h71, 0);
    step();
    check("mr_grant", a_gnt, 3);
    step();
    check("mr_d71", a_odat, 8'h71);
    rst = 1'b1;
    #1;
    check("mr_ovld",  a_ovld, 0);
    check("mr_odat",  a_odat, 0);
    check("mr_grant0", a_gnt, 0);
    check("mr_busy",  a_busy, 0);
    check("mr_rdy",   a_rdy,  0);
    a_set(3, 1, 8'h72, 1);
    step();
    check("mr_hold_busy", a_busy, 0);
    check("mr_hold_ovld", a_ovld, 0);
    rst = 1'b0;
    step();
    check("mr_first_grant", a_gnt,  3);
    check("mr_first_busy",  a_busy, 1);
    step();
    check("mr_d72", a_odat, 8'h72);
    a_set(3, 0, 8'h00, 0);
    step();

    // fixed priority: ch0 always beats ch3 until ch0 drops
    b_set(0, 1, 8'h0A, 1);
    b_set(3, 1, 8'h3A, 1);
    repeat (3) begin
      step();
      check("fp_grant0", b_gnt, 0);
      step();
      check("fp_d0A", b_odat, 8'h0A);
    end
    b_set(0, 0, 8'h00, 0);
    step();
    check("fp_grant3", b_gnt, 3);
    step();
    check("fp_d3A", b_odat, 8'h3A);
    b_set(3, 0, 8'h00, 0);
    step();
    check("fp_drain", b_ovld, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter W, default 8: data width per channel, 1..32.
REQ-003 SHALL have parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-004 SHALL use a single clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be as follows:
  - clk  in  1  clock; all state changes on its rising edge.
  - rst  in  1  async active-high reset.
  - in_valid  in  N  per-channel beat valid.
  - in_data  in  N*W  channel i occupies bits [i*W+W-1 : i*W].
  - in_last  in  N  per-channel end-of-packet flag.
  - in_ready  out  N  per-channel beat accepted.
  - out_valid  out  1  output beat valid.
  - out_data  out  W  output beat data.
  - out_last  out  1  output end-of-packet.
  - out_ready  in  1  downstream accepts beat.
  - grant  out  clog2(N)  index of the currently locked channel.
  - busy  out  1  high while in the LOCK state.

Function
REQ-006 SHALL transfer a beat on any port when valid and ready are both high on the same rising edge.
REQ-007 SHALL implement the states IDLE and LOCK.
REQ-008 IDLE: if any in_valid bit is high, the arbiter SHALL select a winner, load grant, and move to LOCK in the same cycle. No input beat is accepted in IDLE.
REQ-009 LOCK: in_ready[grant] SHALL equal the output-register-free condition; every other in_ready bit SHALL be 0.
REQ-010 The output-register-free condition SHALL be (!out_valid || out_ready).
REQ-011 On an accepted input beat, the block SHALL register in_data and in_last into out_data and out_last and set out_valid.
REQ-012 Input-to-output latency SHALL be exactly 1 cycle.
REQ-013 With out_ready held high, throughput SHALL be 1 beat per cycle.
REQ-014 When out_valid is high and out_ready is low, out_data and out_last SHALL hold stable.
REQ-015 When a beat with in_last=1 is accepted, the block SHALL return to IDLE on the next edge; the following packet arbitrates without re-entering LOCK on the same channel in that edge.
REQ-016 With RR=1, the search SHALL start at (last grant + 1) mod N and wrap from N-1 to 0.
REQ-017 With RR=0, the lowest-index valid channel SHALL always win.
REQ-018 The first arbitration after reset SHALL search from channel 0.
REQ-019 Channels whose in_valid rises while another channel is locked SHALL wait; they are never dropped or reordered.
REQ-020 A single-beat packet (in_last=1 on the first beat) SHALL be legal: LOCK lasts 1 accepting cycle.
REQ-021 The output register SHALL drain independently of state. out_valid SHALL clear when out_ready is high and no new beat is accepted.
REQ-022 Deassertion of in_valid[grant] mid-packet SHALL keep LOCK; the block waits and performs no re-arbitration.

Reset
REQ-023 While rst=1, the block SHALL hold: state IDLE, out_valid 0, out_data 0, out_last 0, grant 0, busy 0, in_ready all 0, and round-robin pointer 0.
REQ-024 Reset asserted mid-packet SHALL discard the held output beat and the lock; there is no partial-packet recovery.
REQ-025 After rst falls, the first arbitration SHALL be possible on the first rising edge.

Structure
REQ-026 State encodings (IDLE=0, LOCK=1) and parameter bounds SHALL live in shared include file mux_defs.vh, reused by later mux blocks.
REQ-027 Arbitration SHALL be one sub-module, rr_arbiter_n, with parameters N and RR. It SHALL take a request vector and a last-grant index and return a combinational winner index plus a found flag.
REQ-028 The block SHALL be synthesizable Verilog-2001 for Spartan-3, with no latches, and in_data slicing via generate.

Verification
REQ-029 The bench SHALL cover these scenarios:
  - Reset check: rst pulsed mid-packet -> next cycle out_valid=0, grant=0, busy=0, all in_ready=0.
  - Single channel: N=4, W=8, ch2 sends a 3-beat packet 0x11, 0x22, 0x33(last) with out_ready=1 -> out_data shows 11, 22, 33 on consecutive cycles, 1 cycle after each accept; busy falls after 0x33.
  - Round-robin fairness: RR=1, all 4 channels continuously valid with single-beat packets -> grant sequence 0, 1, 2, 3, 0; no channel is served twice before the others.
  - Fixed priority: RR=0, ch0 and ch3 valid continuously -> only ch0 is granted; ch3 is served only after ch0's in_valid drops.
  - Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data stable, in_ready[grant]=0, no beat lost or duplicated after release.
  - Lock hold: ch1 drops in_valid mid-packet while ch0 is valid -> grant stays 1 until ch1 completes with last=1.
